// File: rtl/c432_key_loader.sv
// c432_key_loader: serial key provisioning for the obfuscated c432 netlist with parity check and failure lockout
//
// Ports:
//   clk, rst      single clock, synchronous active-high reset
//   load_start_i  request a new key load (honoured in IDLE and DONE only)
//   key_bit_i     serial key data, LSB first, then the parity bit when enabled
//   key_valid_i   key_bit_i is valid this cycle
//   key_ready_o   a bit is accepted this cycle (SHIFT state)
//   key_o         committed key, zero unless key_valid_o; key_o[0]->D_0, key_o[1]->D_1
//   key_valid_o   key_o holds a checked, committed key
//   err_o         one-cycle pulse on a failed check
//   fail_cnt_o    saturating count of failed loads since reset
//   locked_o      permanently locked until rst
//
// Optional feature: define C432_KEY_PARITY_EN to append an even-parity bit to each
// frame, enabling err_o, fail counting and the LOCKED state. Undefined, every frame passes.
module c432_key_loader #(
  parameter int KEY_W = 2,
  parameter int MAX_FAIL = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start_i,
  input  logic             key_bit_i,
  input  logic             key_valid_i,
  output logic             key_ready_o,
  output logic [KEY_W-1:0] key_o,
  output logic             key_valid_o,
  output logic             err_o,
  output logic [3:0]       fail_cnt_o,
  output logic             locked_o
);
`ifdef C432_KEY_PARITY_EN
  localparam int FRAME = KEY_W + 1;
`else
  localparam int FRAME = KEY_W;
`endif
  localparam int CW = $clog2(FRAME + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);
  localparam logic [3:0] MAX_F = 4'(MAX_FAIL);
  localparam logic [2:0] IDLE = 3'd0, SHIFT = 3'd1, CHECK = 3'd2, DONE = 3'd3, LOCKED = 3'd4;
  logic [2:0]       state;
  logic [FRAME-1:0] sreg;
  logic [CW-1:0]    bit_cnt;
  logic [KEY_W-1:0] key_q;
  logic             kv_q, err_q, pass;
  logic [3:0]       fail_q, fail_n;
`ifdef C432_KEY_PARITY_EN
  assign pass = ~^sreg;
  assign fail_n = fail_q == 4'd15 ? 4'd15 : fail_q + 4'd1;
`else
  assign pass = 1'b1;
  assign fail_n = fail_q;
`endif
  assign key_ready_o = state == SHIFT;
  assign locked_o = state == LOCKED;
  assign key_o = key_q;
  assign key_valid_o = kv_q;
  assign err_o = err_q;
  assign fail_cnt_o = fail_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sreg <= '0;
      bit_cnt <= '0;
      key_q <= '0;
      kv_q <= 1'b0;
      err_q <= 1'b0;
      fail_q <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE, DONE: if (load_start_i) begin
          state <= SHIFT;
          sreg <= '0;
          bit_cnt <= '0;
          key_q <= '0;
          kv_q <= 1'b0;
        end
        SHIFT: if (key_valid_i) begin
          for (int i = 0; i < FRAME; i++) if (bit_cnt == CW'(i)) sreg[i] <= key_bit_i;
          bit_cnt <= bit_cnt + CW'(1);
          if (bit_cnt == LAST) state <= CHECK;
        end
        CHECK: if (pass) begin
          key_q <= sreg[KEY_W-1:0];
          kv_q <= 1'b1;
          state <= DONE;
        end else begin
          err_q <= 1'b1;
          fail_q <= fail_n;
          state <= fail_n >= MAX_F ? LOCKED : IDLE;
        end
        LOCKED: ;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
